booth_pp_gen: RTL
=================

// Module: booth_pp_gen
// PURPOSE
//  Radix-4 Booth partial-product generator, 2-stage pipelined, valid/ready on both sides.
//  Takes two HALF-bit operands and emits N sign-extended DW-bit partial products.
//  Output feeds the compressor32 Wallace tree directly (its add_i, same DW/N).
//  Invariant: sum(pp_o[j]) mod 2^DW == a*b (signed or unsigned per signed_i).
// PARAMETERS
//  HALF  8           operand width in bits; even, >= 4
//  DW    2*HALF      partial-product / product width
//  N     HALF/2+1    number of partial products (Booth digits)
// PORTS
//  clk_i     in   1         clock
//  rst_i     in   1         synchronous reset, active high
//  valid_i   in   1         input operands valid
//  ready_o   out  1         block accepts input this cycle
//  signed_i  in   1         1: a_i/b_i two's complement; 0: unsigned
//  a_i       in   HALF      multiplicand
//  b_i       in   HALF      multiplier (Booth-recoded)
//  valid_o   out  1         pp_o valid
//  ready_i   in   1         downstream accepts pp_o
//  pp_o      out  N*DW      [N-1:0][DW-1:0] partial products
// BEHAVIOUR
//  Reset: valid_o=0, both stage-valid flags=0, pp_o=0, stage data regs=0. Reset wins over any transfer.
//  Handshake: transfer on valid && ready, at each side. adv2 = !v2 | ready_i; adv1 = !v1 | adv2.
//   ready_o = adv1. This is a combinational path from ready_i; no skid buffer.
//  Stage 1 (on valid_i & ready_o): register the extended operands and the N Booth digit codes.
//   a_ext  = DW bits, sign-extended if signed_i else zero-extended.
//   b_ext  = {e,e,b_i,1'b0}, HALF+3 bits; e = signed_i & b_i[HALF-1].
//   digit j = b_ext[2j+2:2j], for j=0..N-1:
//    000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
//  Stage 2 (on adv2 & v1): pp[j] = (digit_j * a_ext) << 2j, truncated to DW bits.
//   Negation is full two's complement inside the PP (~x+1), with no separate neg bit.
//   Capture the result into the pp_o regs.
//  v1 is set on an input transfer and cleared when stage 1 advances without a new input.
//   v2 follows the same rule with respect to stage 1.
//  Latency: 2 cycles from the accepting edge to valid_o. Throughput: 1 per cycle when ready_i=1.
//  Stall: while valid_o & !ready_i, pp_o and valid_o stay stable.
//   Stage 1 holds if it is full. ready_o=0 only when both stages are full and ready_i=0.
//  Simultaneous output drain and input accept: both occur in the same cycle, with no bubble.
//  valid_i deasserting with no transfer is legal. Inputs are sampled only on a transfer.
//  Edge operands: a = -2^(HALF-1) with digit -2 wraps correctly mod 2^DW.
//   Zero operands give all-zero PPs.
//  No combinational path from the a_i/b_i data to outputs. pp_o is registered.
// TESTING
//  1 Reset held 3 cycles with valid_i=1 -> valid_o=0, pp_o=0, no transfer. ready_o=1 after release.
//  2 unsigned a=3,b=2 -> after 2 cycles pp_o[0]=16'hFFFA, pp_o[1]=16'h000C, pp_o[2..4]=0; sum=6.
//  3 Random a,b, both modes, 10k vectors, ready_i=1 ->
//    sum(pp_o) mod 2^16 equals a*b (e.g. 255*255 unsigned = 16'hFE01;
//    signed -128*-128 = 16'h4000; signed -1*127 = 16'hFF81); valid_o every cycle after fill.
//  4 Back-pressure: ready_i=0 for 5 cycles with 3 inputs offered ->
//    2 accepted, ready_o=0 after that, pp_o stable. On release, in-order output with no loss or duplication.
//  5 rst_i pulsed 1 cycle with both stages full -> next cycle valid_o=0; stale results never emitted.
//  6 ready_i toggling 1010... with continuous valid_i ->
//    outputs match a scoreboard in order, and ready_o never deasserts while a stage is free.

Source files
------------

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator with a two-stage valid/ready pipeline.
// Stage 1 captures the extended multiplicand and Booth digit codes; stage 2 forms the partial products.
module booth_pp_gen #(
  parameter int HALF = 8,
  parameter int DW   = 2 * HALF,
  parameter int N    = HALF / 2 + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 signed_i,
  input  logic [HALF-1:0]      a_i,
  input  logic [HALF-1:0]      b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [N-1:0][DW-1:0] pp_o
);

  logic                 v1_r;
  logic                 v2_r;
  logic                 adv1_s;
  logic                 adv2_s;
  logic                 in_fire_s;
  logic                 ext_bit_s;
  logic [DW-1:0]        a_ext_s;
  logic [HALF+2:0]      b_ext_s;
  logic [N-1:0][2:0]    digit_s;
  logic [DW-1:0]        a_ext_r;
  logic [N-1:0][2:0]    digit_r;
  logic [N-1:0][DW-1:0] pp_s;
  logic [N-1:0][DW-1:0] pp_r;

  // Booth digit times multiplicand; negative digits use a full two's complement.
  function automatic logic [DW-1:0] booth_term(input logic [2:0] code, input logic [DW-1:0] a);
    logic [DW-1:0] two_a;
    logic [DW-1:0] term;
    two_a = a << 1;
    term  = {DW{1'b0}};
    case (code)
      3'b001, 3'b010: term = a;
      3'b011:         term = two_a;
      3'b100:         term = ~two_a + {{(DW-1){1'b0}}, 1'b1};
      3'b101, 3'b110: term = ~a + {{(DW-1){1'b0}}, 1'b1};
      default:        term = {DW{1'b0}};
    endcase
    return term;
  endfunction

  // Handshake: ready_o is combinational from ready_i, there is no skid buffer.
  always_comb begin
    adv2_s    = !v2_r || ready_i;
    adv1_s    = !v1_r || adv2_s;
    in_fire_s = valid_i && adv1_s;
  end

  assign ready_o = adv1_s;
  assign valid_o = v2_r;
  assign pp_o    = pp_r;

  // Operand extension and overlapping 3-bit Booth windows of the multiplier.
  always_comb begin
    ext_bit_s = signed_i & b_i[HALF-1];
    if (signed_i) begin
      a_ext_s = {{(DW-HALF){a_i[HALF-1]}}, a_i};
    end else begin
      a_ext_s = {{(DW-HALF){1'b0}}, a_i};
    end
    b_ext_s = {ext_bit_s, ext_bit_s, b_i, 1'b0};
    for (int j = 0; j < N; j++) begin
      digit_s[j] = b_ext_s[2*j +: 3];
    end
  end

  // Partial products weighted by 4^j and truncated to DW bits.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      pp_s[j] = booth_term(digit_r[j], a_ext_r) << (2 * j);
    end
  end

  // Stage occupancy flags; stage 1 empties when it advances without a new input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      if (in_fire_s) begin
        v1_r <= 1'b1;
      end else if (adv1_s) begin
        v1_r <= 1'b0;
      end
      if (adv2_s) begin
        v2_r <= v1_r;
      end
    end
  end

  // Stage 1 data, loaded only on an input transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_ext_r <= {DW{1'b0}};
      digit_r <= {(3*N){1'b0}};
    end else if (in_fire_s) begin
      a_ext_r <= a_ext_s;
      digit_r <= digit_s;
    end
  end

  // Stage 2 data, held stable while the output is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pp_r <= {(N*DW){1'b0}};
    end else if (adv2_s && v1_r) begin
      pp_r <= pp_s;
    end
  end

endmodule
